obi_bram_bridge: RTL and testbench

- Adapts the core's req/gnt/rvalid memory interface (instruction or data side) to a single-port BRAM port with a fixed read latency.
- Sits between the processor memory port and the word-addressed BRAM primitive.
- Converts byte addresses to word addresses and maps byte enables.
- Tracks the single outstanding transaction and flags out-of-range accesses.
- Keeps saturating read and write access counters for trace/cache comparison runs.

---
 rtl/obi_bram_bridge_if.sv | 48 ++++
 rtl/obi_bram_bridge.sv | 119 +++++++++++
 tb/tb_obi_bram_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/obi_bram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : obi_bram_bridge_if
// Purpose  : Bundle of the core req/gnt/rvalid port, the BRAM port and the
//            access counters that connect to obi_bram_bridge.
// Revision : 1.0  initial release
// ============================================================================
interface obi_bram_bridge_if #(
   parameter int BRAM_ADDR_WIDTH = 17
);
   // core side
   logic                        req_i;
   logic                        gnt_o;
   logic [31:0]                 addr_i;
   logic                        we_i;
   logic [3:0]                  be_i;
   logic [31:0]                 wdata_i;
   logic                        rvalid_o;
   logic [31:0]                 rdata_o;
   logic                        err_o;
   // BRAM side
   logic [BRAM_ADDR_WIDTH-1:0]  bram_addr_o;
   logic                        bram_en_o;
   logic [3:0]                  bram_we_o;
   logic [31:0]                 bram_wrdata_o;
   logic [31:0]                 bram_rddata_i;
   logic                        bram_rst_o;
   // statistics
   logic [31:0]                 rd_count_o;
   logic [31:0]                 wr_count_o;

   // bridge view
   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i, bram_rddata_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
             bram_addr_o, bram_en_o, bram_we_o, bram_wrdata_o, bram_rst_o,
             rd_count_o, wr_count_o
   );

   // core / BRAM environment view
   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i, bram_rddata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
             bram_addr_o, bram_en_o, bram_we_o, bram_wrdata_o, bram_rst_o,
             rd_count_o, wr_count_o
   );
endinterface
`default_nettype wire

// File: rtl/obi_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : obi_bram_bridge
// Purpose  : Adapts a req/gnt/rvalid memory port to a single-port BRAM with
//            fixed read latency. One outstanding transaction, out-of-range
//            error responses, saturating read/write access counters.
// Revision : 1.0  initial release
// ============================================================================
module obi_bram_bridge #(
   parameter int          BRAM_ADDR_WIDTH = 17,
   parameter int          DATA_WIDTH      = 32,
   parameter int          READ_LATENCY    = 1,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter logic [31:0] ERR_DATA        = 32'hEEEE_EEEE
) (
   input  logic              clk,
   input  logic              reset,
   obi_bram_bridge_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // latency counter preload: WAIT lasts READ_LATENCY cycles
   localparam logic [1:0]  c_lat_init = 2'(READ_LATENCY - 1);
   localparam logic [31:0] c_cnt_max  = 32'hFFFF_FFFF;

   state_t      r_state;
   logic [1:0]  r_lat_cnt;
   logic        r_txn_err;
   logic        r_txn_write;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;

   logic [31:0] w_off;
   logic        w_in_range;
   logic        w_gnt;

   // offset from the BRAM window base; the shift test avoids overflow of BASE+size
   assign w_off      = bus.addr_i - BASE_ADDR;
   assign w_in_range = (bus.addr_i >= BASE_ADDR) &&
                       ((w_off >> (BRAM_ADDR_WIDTH + 2)) == 32'd0);
   assign w_gnt      = bus.req_i && ((r_state == S_IDLE) || (r_state == S_RESP));

   assign bus.gnt_o         = w_gnt;
   assign bus.rvalid_o      = (r_state == S_RESP);
   assign bus.rdata_o       = r_rdata;
   assign bus.err_o         = r_err;
   assign bus.bram_en_o     = w_gnt && w_in_range;
   assign bus.bram_we_o     = (w_gnt && w_in_range && bus.we_i) ? bus.be_i : 4'b0000;
   assign bus.bram_addr_o   = w_off[BRAM_ADDR_WIDTH+1:2];
   assign bus.bram_wrdata_o = bus.wdata_i;
   assign bus.bram_rst_o    = reset;
   assign bus.rd_count_o    = r_rd_count;
   assign bus.wr_count_o    = r_wr_count;

   // transaction FSM: grant -> WAIT (READ_LATENCY cycles) -> RESP, response captured on entry to RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_lat_cnt   <= 2'd0;
         r_txn_err   <= 1'b0;
         r_txn_write <= 1'b0;
         r_rdata     <= 32'd0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_RESP: begin
               if (bus.req_i) begin
                  r_state     <= S_WAIT;
                  r_lat_cnt   <= c_lat_init;
                  r_txn_err   <= !w_in_range;
                  r_txn_write <= bus.we_i;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (r_lat_cnt == 2'd0) begin
                  r_state <= S_RESP;
                  r_err   <= r_txn_err;
                  if (r_txn_err)
                     r_rdata <= ERR_DATA;
                  else if (r_txn_write)
                     r_rdata <= 32'd0;
                  else
                     r_rdata <= bus.bram_rddata_i;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // saturating access counters, stepped only at the grant of in-range accesses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_count <= 32'd0;
         r_wr_count <= 32'd0;
      end else if (w_gnt && w_in_range) begin
         if (bus.we_i) begin
            if (r_wr_count != c_cnt_max)
               r_wr_count <= r_wr_count + 32'd1;
         end else begin
            if (r_rd_count != c_cnt_max)
               r_rd_count <= r_rd_count + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_obi_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_bram_bridge
// Purpose  : Directed self-checking bench for obi_bram_bridge with a
//            latency-accurate BRAM model (READ_LATENCY = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_obi_bram_bridge;

   localparam int LAT = 2;
   localparam int AW  = 17;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   obi_bram_bridge_if #(.BRAM_ADDR_WIDTH(AW)) bus ();

   obi_bram_bridge #(
      .BRAM_ADDR_WIDTH (AW),
      .DATA_WIDTH      (32),
      .READ_LATENCY    (LAT),
      .BASE_ADDR       (32'h0000_0000),
      .ERR_DATA        (32'hEEEE_EEEE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: byte-writeable, read-first, LAT-stage output pipeline
   logic [31:0] mem  [0:255];
   logic [31:0] pipe [0:LAT-1];

   always @(posedge clk) begin
      if (bus.bram_en_o) begin
         for (int i = 0; i < 4; i++)
            if (bus.bram_we_o[i])
               mem[bus.bram_addr_o[7:0]][8*i +: 8] <= bus.bram_wrdata_o[8*i +: 8];
         pipe[0] <= mem[bus.bram_addr_o[7:0]];
      end
      for (int i = 1; i < LAT; i++)
         pipe[i] <= pipe[i-1];
   end
   assign bus.bram_rddata_i = pipe[LAT-1];

   // one request held for its grant cycle only; returns grant-cycle and response observations
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d,
                        output logic g, output logic en, output logic [3:0] bwe,
                        output logic [AW-1:0] baddr, output int lat,
                        output logic [31:0] rd, output logic e);
      @(negedge clk);
      bus.req_i   = 1'b1;
      bus.addr_i  = a;
      bus.we_i    = w;
      bus.be_i    = b;
      bus.wdata_i = d;
      #1;
      g     = bus.gnt_o;
      en    = bus.bram_en_o;
      bwe   = bus.bram_we_o;
      baddr = bus.bram_addr_o;
      lat   = 0;
      do begin
         @(negedge clk);
         bus.req_i = 1'b0;
         lat++;
      end while (!bus.rvalid_o && lat < 20);
      rd = bus.rdata_o;
      e  = bus.err_o;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (bus.rvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid_o); end
      n_checks++; if (bus.rdata_o !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
      n_checks++; if (bus.bram_rst_o !== 1'b1) begin n_errors++; $display("FAIL reset_bram_rst got=%b exp=1", bus.bram_rst_o); end
      n_checks++; if (bus.rd_count_o !== 32'd0 || bus.wr_count_o !== 32'd0) begin n_errors++; $display("FAIL reset_counters rd=%h wr=%h exp=0", bus.rd_count_o, bus.wr_count_o); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if (bus.bram_rst_o !== 1'b0) begin n_errors++; $display("FAIL reset_release_bram_rst got=%b exp=0", bus.bram_rst_o); end
   endtask

   task automatic test_read();
      logic g, en, e; logic [3:0] bwe; logic [AW-1:0] ba; int lat; logic [31:0] rd;
      issue(32'h40, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (g !== 1'b1 || en !== 1'b1 || bwe !== 4'b0) begin n_errors++; $display("FAIL read_grant gnt=%b en=%b we=%b exp 1 1 0000", g, en, bwe); end
      n_checks++; if (ba !== 17'h10) begin n_errors++; $display("FAIL read_addr got=%h exp=10", ba); end
      n_checks++; if (lat !== LAT + 1) begin n_errors++; $display("FAIL read_latency got=%0d exp=%0d", lat, LAT + 1); end
      n_checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_errors++; $display("FAIL read_data got=%h err=%b exp=deadbeef 0", rd, e); end
      n_checks++; if (bus.rd_count_o !== 32'd1) begin n_errors++; $display("FAIL read_count got=%0d exp=1", bus.rd_count_o); end
   endtask

   task automatic test_write();
      logic g, en, e; logic [3:0] bwe; logic [AW-1:0] ba; int lat; logic [31:0] rd;
      issue(32'h44, 1'b1, 4'b0110, 32'h11223344, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (g !== 1'b1 || en !== 1'b1 || bwe !== 4'b0110 || ba !== 17'h11) begin n_errors++; $display("FAIL write_grant gnt=%b en=%b we=%b addr=%h exp 1 1 0110 11", g, en, bwe, ba); end
      n_checks++; if (lat !== LAT + 1 || rd !== 32'd0 || e !== 1'b0) begin n_errors++; $display("FAIL write_resp lat=%0d rdata=%h err=%b exp %0d 0 0", lat, rd, e, LAT + 1); end
      n_checks++; if (bus.wr_count_o !== 32'd1) begin n_errors++; $display("FAIL write_count got=%0d exp=1", bus.wr_count_o); end
      issue(32'h46, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (rd !== 32'hAA2233DD) begin n_errors++; $display("FAIL write_readback got=%h exp=aa2233dd", rd); end
      // byte enables all clear: enabled, nothing written, still counted
      issue(32'h48, 1'b1, 4'b0000, 32'hFFFFFFFF, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (en !== 1'b1 || bwe !== 4'b0 || lat !== LAT + 1 || bus.wr_count_o !== 32'd2) begin n_errors++; $display("FAIL write_be0 en=%b we=%b lat=%0d wr=%0d exp 1 0000 %0d 2", en, bwe, lat, bus.wr_count_o, LAT + 1); end
      issue(32'h48, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (rd !== 32'h0000_0033) begin n_errors++; $display("FAIL write_be0_readback got=%h exp=00000033", rd); end
   endtask

   task automatic test_back_to_back();
      int g_cyc [3];
      int rv_cyc [3];
      logic [31:0] rv_dat [3];
      int idx = 0;
      int nrv = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (idx < 3) begin
            bus.req_i  = 1'b1;
            bus.we_i   = 1'b0;
            bus.addr_i = 32'(idx * 4);
         end else begin
            bus.req_i = 1'b0;
         end
         #1;
         if (bus.rvalid_o && nrv < 3) begin rv_cyc[nrv] = c; rv_dat[nrv] = bus.rdata_o; nrv++; end
         if (bus.gnt_o && idx < 3) begin g_cyc[idx] = c; idx++; end
      end
      bus.req_i = 1'b0;
      n_checks++; if (idx !== 3 || nrv !== 3) begin n_errors++; $display("FAIL b2b_counts grants=%0d resps=%0d exp 3 3", idx, nrv); end
      for (int k = 0; k < 3; k++) begin
         if (k < idx && k < nrv) begin
            n_checks++; if (g_cyc[k] !== 3 * k || rv_cyc[k] !== 3 * k + 3) begin n_errors++; $display("FAIL b2b_timing_%0d gnt=%0d rvalid=%0d exp %0d %0d", k, g_cyc[k], rv_cyc[k], 3 * k, 3 * k + 3); end
            n_checks++; if (rv_dat[k] !== 32'hC0DE_0000 + 32'(k)) begin n_errors++; $display("FAIL b2b_data_%0d got=%h exp=%h", k, rv_dat[k], 32'hC0DE_0000 + 32'(k)); end
         end
      end
      n_checks++; if (bus.rd_count_o !== 32'd6) begin n_errors++; $display("FAIL b2b_count got=%0d exp=6", bus.rd_count_o); end
   endtask

   task automatic test_out_of_range();
      logic g, en, e; logic [3:0] bwe; logic [AW-1:0] ba; int lat; logic [31:0] rd;
      issue(32'h0008_0000, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (g !== 1'b1 || en !== 1'b0) begin n_errors++; $display("FAIL oor_grant gnt=%b en=%b exp 1 0", g, en); end
      n_checks++; if (lat !== LAT + 1 || e !== 1'b1 || rd !== 32'hEEEE_EEEE) begin n_errors++; $display("FAIL oor_resp lat=%0d err=%b rdata=%h exp %0d 1 eeeeeeee", lat, e, rd, LAT + 1); end
      issue(32'hFFFF_FFFC, 1'b1, 4'hF, 32'h5555_5555, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (en !== 1'b0 || bwe !== 4'b0 || e !== 1'b1) begin n_errors++; $display("FAIL oor_write en=%b we=%b err=%b exp 0 0000 1", en, bwe, e); end
      n_checks++; if (bus.rd_count_o !== 32'd6 || bus.wr_count_o !== 32'd2) begin n_errors++; $display("FAIL oor_counters rd=%0d wr=%0d exp 6 2", bus.rd_count_o, bus.wr_count_o); end
      // last in-range word is still served
      issue(32'h0007_FFFC, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (en !== 1'b1 || ba !== 17'h1FFFF || e !== 1'b0) begin n_errors++; $display("FAIL top_word en=%b addr=%h err=%b exp 1 1ffff 0", en, ba, e); end
   endtask

   task automatic test_reset_in_wait();
      int seen = 0;
      logic g, en, e; logic [3:0] bwe; logic [AW-1:0] ba; int lat; logic [31:0] rd;
      @(negedge clk);
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h40;
      @(negedge clk);
      bus.req_i = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 32'd0 || bus.err_o !== 1'b0) begin n_errors++; $display("FAIL rst_wait_outputs rvalid=%b rdata=%h err=%b exp 0", bus.rvalid_o, bus.rdata_o, bus.err_o); end
      n_checks++; if (bus.rd_count_o !== 32'd0 || bus.wr_count_o !== 32'd0 || bus.bram_rst_o !== 1'b1) begin n_errors++; $display("FAIL rst_wait_counters rd=%h wr=%h bram_rst=%b exp 0 0 1", bus.rd_count_o, bus.wr_count_o, bus.bram_rst_o); end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.rvalid_o) seen++;
      end
      n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL rst_wait_stale_rvalid got=%0d exp=0", seen); end
      issue(32'h40, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
      n_checks++; if (lat !== LAT + 1 || rd !== 32'hDEADBEEF || bus.rd_count_o !== 32'd1) begin n_errors++; $display("FAIL rst_wait_fresh lat=%0d rdata=%h rd=%0d exp %0d deadbeef 1", lat, rd, bus.rd_count_o, LAT + 1); end
   endtask

   task automatic test_saturation();
      logic g, en, e; logic [3:0] bwe; logic [AW-1:0] ba; int lat; logic [31:0] rd;
      @(negedge clk);
      force dut.r_rd_count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.r_rd_count;
      for (int k = 0; k < 3; k++) begin
         issue(32'h40, 1'b0, 4'hF, 32'h0, g, en, bwe, ba, lat, rd, e);
         n_checks++; if (bus.rd_count_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_read_%0d got=%h exp=ffffffff", k, bus.rd_count_o); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
      mem[0]  = 32'hC0DE_0000;
      mem[1]  = 32'hC0DE_0001;
      mem[2]  = 32'hC0DE_0002;
      mem[16] = 32'hDEADBEEF;
      mem[17] = 32'hAABBCCDD;
      mem[18] = 32'h0000_0033;
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      bus.req_i   = 1'b0;
      bus.addr_i  = 32'h0;
      bus.we_i    = 1'b0;
      bus.be_i    = 4'h0;
      bus.wdata_i = 32'h0;

      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_out_of_range();
      test_reset_in_wait();
      test_saturation();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
